// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer, I-cache req/gnt issue, instruction buffer for decode, redirect squash.
// Define FETCH_PERF_EN to add saturating fetch/drop/stall performance counter outputs.
module fetch_ctrl #(
  parameter int              ADDR       = 32,
  parameter int              INST       = 32,
  parameter logic [ADDR-1:0] RESET_VEC  = '0,
  parameter int              IBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            fetch_req,
  output logic [ADDR-1:0] fetch_pc,
  input  logic            fetch_gnt,
  input  logic            ic_valid,
  input  logic [INST-1:0] ic_inst,
  input  logic            redirect_valid,
  input  logic [ADDR-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [ADDR-1:0] dec_pc,
  output logic [INST-1:0] dec_inst,
  input  logic            dec_ready,
  output logic [1:0]      dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int CW   = $clog2(IBUF_DEPTH + 1);
  localparam int PW   = $clog2(IBUF_DEPTH);
  localparam int STEP = INST / 8;
  localparam logic [ADDR-1:0] STEP_W     = ADDR'(STEP);
  localparam logic [ADDR-1:0] ALIGN_MASK = ~(STEP_W - 1'b1);
  localparam logic [CW:0]     DEPTH_W    = IBUF_DEPTH[CW:0];

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t          r_state, w_state_nx;
  logic [ADDR-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outst, r_drop, r_count, w_outst_nx;
  logic [PW-1:0]   r_pcq_wr, r_pcq_rd, r_ib_wr, r_ib_rd;
  logic [ADDR-1:0] r_pcq     [IBUF_DEPTH];
  logic [ADDR-1:0] r_ib_pc   [IBUF_DEPTH];
  logic [INST-1:0] r_ib_inst [IBUF_DEPTH];
  logic            w_credit_ok, w_fire, w_resp, w_push, w_pop;

  // Handshakes: a request transfers when fetch_req & fetch_gnt, a response when ic_valid
  // (no backpressure), a decode pop when dec_valid & dec_ready; req/pc hold until gnt
  // unless a redirect withdraws the request.
  assign w_credit_ok = ({1'b0, r_outst} + {1'b0, r_count}) < DEPTH_W;
  assign fetch_req   = (r_state == S_RUN) && w_credit_ok && !redirect_valid;
  assign w_fire      = fetch_req && fetch_gnt;
  assign w_resp      = ic_valid && (r_outst != '0);
  assign w_push      = w_resp && (r_state == S_RUN) && !redirect_valid;
  assign w_pop       = dec_valid && dec_ready;
  assign w_outst_nx  = r_outst + CW'(w_fire) - CW'(w_resp);

  assign fetch_pc  = r_fetch_pc;
  assign dec_valid = (r_count != '0);
  assign dec_pc    = r_ib_pc[r_ib_rd];
  assign dec_inst  = r_ib_inst[r_ib_rd];
  assign dbg_state = r_state;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_BOOT:  w_state_nx = S_RUN;
      S_RUN:   if (redirect_valid && (w_outst_nx != '0)) w_state_nx = S_DRAIN;
      S_DRAIN: begin
        if (redirect_valid)
          w_state_nx = (w_outst_nx != '0) ? S_DRAIN : S_RUN;
        else if (w_resp && (r_drop == CW'(1)))
          w_state_nx = S_RUN;
      end
      default: w_state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_VEC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_ib_wr    <= '0;
      r_ib_rd    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_outst <= w_outst_nx;
      // The PC tag FIFO tracks every in-flight request, stale or not, so it is never squashed.
      if (w_fire) r_pcq_wr <= r_pcq_wr + 1'b1;
      if (w_resp) r_pcq_rd <= r_pcq_rd + 1'b1;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ALIGN_MASK;
        r_drop     <= w_outst_nx;
        r_count    <= '0;
        r_ib_wr    <= '0;
        r_ib_rd    <= '0;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + STEP_W;
        if ((r_state == S_DRAIN) && w_resp) r_drop <= r_drop - 1'b1;
        if (w_push) r_ib_wr <= r_ib_wr + 1'b1;
        if (w_pop)  r_ib_rd <= r_ib_rd + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) r_pcq[r_pcq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_ib_pc[r_ib_wr]   <= r_pcq[r_pcq_rd];
      r_ib_inst[r_ib_wr] <= ic_inst;
    end
  end

  // A response with nothing outstanding is an I-cache protocol violation; it is ignored.
  always @(posedge clk) begin
    if (!reset) assert (!(ic_valid && (r_outst == '0)));
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_drop, r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_fire && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 1'b1;
      if (w_resp && ((r_state == S_DRAIN) || redirect_valid) && (r_perf_drop != '1))
        r_perf_drop <= r_perf_drop + 1'b1;
      if ((r_state == S_RUN) && !w_credit_ok && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl, checked against a
// queue-based reference model of the I-cache, the outstanding requests and the decode buffer.
module tb_fetch_ctrl;
  localparam int          ADDR      = 32;
  localparam int          INST      = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_VEC = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_gnt = 1'b0;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_inst = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        fetch_req, dec_valid;
  logic [31:0] fetch_pc, dec_pc, dec_inst;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR(ADDR), .INST(INST), .RESET_VEC(RESET_VEC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_gnt(fetch_gnt), .ic_valid(ic_valid), .ic_inst(ic_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .dec_ready(dec_ready),
    .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          due;
  } ic_t;

  ic_t         ic_q[$];     // granted requests not yet answered, in order
  logic [63:0] exp_q[$];    // {pc, inst} expected at decode, in order
  int          cyc = 0;
  int          lat_min = 2, lat_max = 2, ic_rate = 100;
  int          n_cmp = 0, n_err = 0;
  logic        m_boot = 1'b1;
  logic [31:0] m_pc = RESET_VEC;
  int          m_drop = 0;

  // I-cache model: answers in order, no earlier than each request's due cycle.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!reset && (ic_q.size() != 0) && (ic_q[0].due <= cyc) &&
        ($urandom_range(0, 99) < ic_rate)) begin
      ic_valid = 1'b1;
      ic_inst  = ic_q[0].inst;
    end else begin
      ic_valid = 1'b0;
      ic_inst  = $urandom;
    end
  end

  // Scoreboard and reference model, evaluated once per cycle away from the clock edge.
  always @(negedge clk) begin
    logic        exp_req, exp_dv, fire, got;
    ic_t         r, nr;
    if (reset) begin
      ic_q.delete();
      exp_q.delete();
      m_boot = 1'b1;
      m_pc   = RESET_VEC;
      m_drop = 0;
    end else begin
      exp_req = !m_boot && (m_drop == 0) && (ic_q.size() + exp_q.size() < DEPTH) && !redirect_valid;
      exp_dv  = (exp_q.size() != 0);
      n_cmp++;
      if (fetch_req !== exp_req) begin
        n_err++;
        $display("FAIL sb_fetch_req cyc=%0d got=%b exp=%b", cyc, fetch_req, exp_req);
      end
      n_cmp++;
      if (fetch_pc !== m_pc) begin
        n_err++;
        $display("FAIL sb_fetch_pc cyc=%0d got=%h exp=%h", cyc, fetch_pc, m_pc);
      end
      n_cmp++;
      if (dec_valid !== exp_dv) begin
        n_err++;
        $display("FAIL sb_dec_valid cyc=%0d got=%b exp=%b", cyc, dec_valid, exp_dv);
      end
      if (exp_dv) begin
        n_cmp++;
        if ({dec_pc, dec_inst} !== exp_q[0]) begin
          n_err++;
          $display("FAIL sb_dec_data cyc=%0d got=%h exp=%h", cyc, {dec_pc, dec_inst}, exp_q[0]);
        end
      end
      fire = exp_req && fetch_gnt;
      if (exp_dv && dec_ready) void'(exp_q.pop_front());
      got = 1'b0;
      if (ic_valid && (ic_q.size() != 0)) begin
        r   = ic_q.pop_front();
        got = 1'b1;
      end
      if (fire) begin
        nr.pc   = m_pc;
        nr.inst = $urandom;
        nr.due  = cyc + int'($urandom_range(lat_min, lat_max));
        ic_q.push_back(nr);
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        m_drop = ic_q.size();
        m_pc   = redirect_pc & ~32'h3;
      end else if (got) begin
        if (m_drop > 0) m_drop--;
        else exp_q.push_back({r.pc, r.inst});
      end
      m_boot = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Leaves the caller in the first cycle after reset (BOOT), inputs idle.
  task automatic apply_reset();
    reset = 1'b1; fetch_gnt = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_gnt = 1'b1; dec_ready = 1'b1; redirect_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", fetch_req); end
    n_cmp++; if (fetch_pc !== RESET_VEC) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", fetch_pc, RESET_VEC); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL boot_req got=%b exp=0", fetch_req); end
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL run_first_req got=%b exp=1", fetch_req); end
  endtask

  task automatic test_stream();
    int g = 0, d = 0;
    lat_min = 2; lat_max = 2; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_req && fetch_gnt) begin
        n_cmp++;
        if (fetch_pc !== 32'(4 * g)) begin n_err++; $display("FAIL stream_fetch_pc got=%h exp=%h", fetch_pc, 32'(4 * g)); end
        g++;
      end
      if (dec_valid && dec_ready) begin
        n_cmp++;
        if (dec_pc !== 32'(4 * d)) begin n_err++; $display("FAIL stream_dec_pc got=%h exp=%h", dec_pc, 32'(4 * d)); end
        d++;
      end
      tick();
    end
    n_cmp++; if (g != 19) begin n_err++; $display("FAIL stream_grants got=%0d exp=19", g); end
    n_cmp++; if (d != 16) begin n_err++; $display("FAIL stream_decodes got=%0d exp=16", d); end
  endtask

  task automatic test_backpressure();
    int g = 0;
    logic seen = 1'b0;
    lat_min = 2; lat_max = 2; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fetch_req && fetch_gnt) g++;
      tick();
    end
    @(negedge clk);
    n_cmp++; if (g != 4) begin n_err++; $display("FAIL bp_grants got=%0d exp=4", g); end
    n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL bp_req_off got=%b exp=0", fetch_req); end
    n_cmp++; if ({dec_valid, dec_pc} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL bp_head got=%b/%h exp=1/0", dec_valid, dec_pc); end
    tick();
    dec_ready = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fetch_req && fetch_gnt) begin
        seen = 1'b1;
        n_cmp++;
        if (fetch_pc !== 32'h10) begin n_err++; $display("FAIL bp_resume_pc got=%h exp=10", fetch_pc); end
      end
      tick();
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL bp_resume_timeout got=none exp=grant"); end
  endtask

  task automatic test_redirect();
    int n = 0, nresp = 0, bad = 0, last_resp = -1, grant_cyc = -100;
    logic [31:0] first_pc = 32'hdead_beef;
    lat_min = 8; lat_max = 8; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 20 && n < 3; i++) begin
      @(negedge clk);
      if (fetch_req && fetch_gnt) n++;
      if (n < 3) tick();
    end
    tick();
    fetch_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; fetch_gnt = 1'b1;
    for (int i = 0; i < 30 && grant_cyc < 0; i++) begin
      @(negedge clk);
      if (ic_valid) begin nresp++; last_resp = cyc; end
      if (dec_valid) bad++;
      if (fetch_req && fetch_gnt) begin first_pc = fetch_pc; grant_cyc = cyc; end
      tick();
    end
    n_cmp++; if (nresp != 3) begin n_err++; $display("FAIL redir_dropped got=%0d exp=3", nresp); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL redir_dec_valid got=%0d exp=0", bad); end
    n_cmp++; if (first_pc !== 32'h100) begin n_err++; $display("FAIL redir_new_pc got=%h exp=100", first_pc); end
    n_cmp++; if (grant_cyc != last_resp + 1) begin n_err++; $display("FAIL redir_restart got=%0d exp=%0d", grant_cyc, last_resp + 1); end
  endtask

  task automatic test_redirect_collide();
    int exp_drop = -1, nstale = 0, bad = 0;
    logic [31:0] tgt, first_pc = 32'hdead_beef;
    logic seen = 1'b0;
    lat_min = 2; lat_max = 2; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 10 && !ic_valid; i++) tick();
    tgt = $urandom & 32'h0fff_fffc;
    exp_drop = ic_q.size() - 1;
    redirect_valid = 1'b1; redirect_pc = tgt | 32'h2;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ic_valid) nstale++;
      if (dec_valid) bad++;
      if (fetch_req && fetch_gnt) begin seen = 1'b1; first_pc = fetch_pc; end
      tick();
    end
    n_cmp++; if (nstale != exp_drop) begin n_err++; $display("FAIL coll_dropped got=%0d exp=%0d", nstale, exp_drop); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL coll_dec_valid got=%0d exp=0", bad); end
    n_cmp++; if (first_pc !== tgt) begin n_err++; $display("FAIL coll_new_pc got=%h exp=%h", first_pc, tgt); end
  endtask

  task automatic test_gnt_stall();
    logic [31:0] held;
    lat_min = 2; lat_max = 2; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b1;
    repeat (4) tick();
    fetch_gnt = 1'b0;
    @(negedge clk);
    held = fetch_pc;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({fetch_req, fetch_pc} !== {1'b1, held}) begin
        n_err++; $display("FAIL stall_hold got=%b/%h exp=1/%h", fetch_req, fetch_pc, held);
      end
      tick();
      @(negedge clk);
    end
    tick();
    fetch_gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (fetch_pc !== held) begin n_err++; $display("FAIL stall_grant_pc got=%h exp=%h", fetch_pc, held); end
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_pc !== held + 32'd4) begin n_err++; $display("FAIL stall_advance got=%h exp=%h", fetch_pc, held + 32'd4); end
  endtask

  task automatic test_wrap_reset();
    lat_min = 8; lat_max = 8; ic_rate = 100;
    apply_reset();
    fetch_gnt = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hffff_ffff;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({fetch_req, fetch_pc} !== {1'b1, 32'hffff_fffc}) begin n_err++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", fetch_req, fetch_pc); end
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_pc !== 32'h0) begin n_err++; $display("FAIL wrap_zero got=%h exp=0", fetch_pc); end
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL drain_req got=%b exp=0", fetch_req); end
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({fetch_req, dec_valid, fetch_pc} !== {2'b00, RESET_VEC}) begin
      n_err++; $display("FAIL midreset_boot got=%b/%b/%h exp=0/0/%h", fetch_req, dec_valid, fetch_pc, RESET_VEC);
    end
    tick();
    @(negedge clk);
    n_cmp++; if ({fetch_req, fetch_pc} !== {1'b1, RESET_VEC}) begin n_err++; $display("FAIL midreset_run got=%b/%h exp=1/%h", fetch_req, fetch_pc, RESET_VEC); end
  endtask

  task automatic test_random();
    int d = 0;
    lat_min = 1; lat_max = 5; ic_rate = 70;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      fetch_gnt      = ($urandom_range(0, 99) < 75);
      dec_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom;
      @(negedge clk);
      if (dec_valid && dec_ready) d++;
      tick();
    end
    redirect_valid = 1'b0;
    n_cmp++; if (d < 200) begin n_err++; $display("FAIL rand_progress got=%0d exp=>=200", d); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_gnt_stall();
    test_wrap_reset();
    test_random();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
